// File: rtl/rvx10_pkg.sv
// Shared types and constants for the RVX10 core: control bundle, ALU op and result-select encodings.
// The writeback bypass in idex_stage is built only when RVX10_WB_BYPASS_EN is defined.
package rvx10_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int REGA_W_DEF = 5;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10,
      RES_IMM = 2'b11
   } resultsrc_t;

   // Base RV32I ALU ops in the low half, RVX10 custom ops in the high half.
   typedef enum logic [3:0] {
      ALU_ADD  = 4'h0,
      ALU_SUB  = 4'h1,
      ALU_AND  = 4'h2,
      ALU_OR   = 4'h3,
      ALU_XOR  = 4'h4,
      ALU_SLT  = 4'h5,
      ALU_SLL  = 4'h6,
      ALU_SRL  = 4'h7,
      ALU_ANDN = 4'h8,
      ALU_ORN  = 4'h9,
      ALU_XNOR = 4'hA,
      ALU_MIN  = 4'hB,
      ALU_MAX  = 4'hC,
      ALU_MINU = 4'hD,
      ALU_MAXU = 4'hE,
      ALU_ABS  = 4'hF
   } alu_op_t;

   typedef struct packed {
      logic       regwrite;
      logic       memwrite;
      logic       jump;
      logic       branch;
      logic       alusrc;
      resultsrc_t resultsrc;
      alu_op_t    alucontrol;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   // An invalid instruction must not carry any side-effecting control into E.
   function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic v);
      return v ? c : CTRL_BUBBLE;
   endfunction

endpackage

// File: rtl/wb_bypass.sv
// Same-cycle writeback-to-decode operand bypass for one source operand.
// Purely combinational; instantiated by idex_stage when RVX10_WB_BYPASS_EN is defined.
module wb_bypass
   import rvx10_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int REGA_W = REGA_W_DEF
) (
   input  logic              regwrite_w,
   input  logic [REGA_W-1:0] rd_w,
   input  logic [XLEN-1:0]   result_w,
   input  logic [REGA_W-1:0] rs,
   input  logic [XLEN-1:0]   rdata,
   output logic [XLEN-1:0]   opnd
);

   logic hit;

   // x0 is hardwired to zero, so a write to it must never be forwarded.
   assign hit  = regwrite_w && (rd_w != '0) && (rd_w == rs);
   assign opnd = hit ? result_w : rdata;

endmodule

// File: rtl/idex_stage.sv
// Decode-to-execute pipeline register with stall, flush and optional WB->D operand bypass.
// Optional feature: define RVX10_WB_BYPASS_EN to enable the writeback bypass.
module idex_stage
   import rvx10_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int REGA_W = REGA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall_e,
   input  logic              flush_e,
   input  logic              valid_d,
   input  ctrl_t             ctrl_d,
   input  logic [XLEN-1:0]   pc_d,
   input  logic [XLEN-1:0]   pcplus4_d,
   input  logic [REGA_W-1:0] rs1_d,
   input  logic [REGA_W-1:0] rs2_d,
   input  logic [REGA_W-1:0] rd_d,
   input  logic [XLEN-1:0]   rd1_d,
   input  logic [XLEN-1:0]   rd2_d,
   input  logic [XLEN-1:0]   immext_d,
   input  logic              regwrite_w,
   input  logic [REGA_W-1:0] rd_w,
   input  logic [XLEN-1:0]   result_w,
   output logic              valid_e,
   output ctrl_t             ctrl_e,
   output logic [XLEN-1:0]   pc_e,
   output logic [XLEN-1:0]   pcplus4_e,
   output logic [XLEN-1:0]   rd1_e,
   output logic [XLEN-1:0]   rd2_e,
   output logic [XLEN-1:0]   immext_e,
   output logic [REGA_W-1:0] rs1_e,
   output logic [REGA_W-1:0] rs2_e,
   output logic [REGA_W-1:0] rd_e
);

   logic [XLEN-1:0] opnd1;
   logic [XLEN-1:0] opnd2;

`ifdef RVX10_WB_BYPASS_EN
   wb_bypass #(.XLEN(XLEN), .REGA_W(REGA_W)) u_byp1 (
      .regwrite_w (regwrite_w),
      .rd_w       (rd_w),
      .result_w   (result_w),
      .rs         (rs1_d),
      .rdata      (rd1_d),
      .opnd       (opnd1)
   );

   wb_bypass #(.XLEN(XLEN), .REGA_W(REGA_W)) u_byp2 (
      .regwrite_w (regwrite_w),
      .rd_w       (rd_w),
      .result_w   (result_w),
      .rs         (rs2_d),
      .rdata      (rd2_d),
      .opnd       (opnd2)
   );
`else
   // WB ports stay on the boundary so the core wiring is identical in both builds.
   logic unused_wb;
   assign unused_wb = ^{regwrite_w, rd_w, result_w};
   assign opnd1     = rd1_d;
   assign opnd2     = rd2_d;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_e   <= 1'b0;
         ctrl_e    <= CTRL_BUBBLE;
         pc_e      <= '0;
         pcplus4_e <= '0;
         rd1_e     <= '0;
         rd2_e     <= '0;
         immext_e  <= '0;
         rs1_e     <= '0;
         rs2_e     <= '0;
         rd_e      <= '0;
      end else if (flush_e) begin
         // Flush wins over stall; any bypassed operand is discarded with the bubble.
         valid_e   <= 1'b0;
         ctrl_e    <= CTRL_BUBBLE;
         pc_e      <= '0;
         pcplus4_e <= '0;
         rd1_e     <= '0;
         rd2_e     <= '0;
         immext_e  <= '0;
         rs1_e     <= '0;
         rs2_e     <= '0;
         rd_e      <= '0;
      end else if (!stall_e) begin
         valid_e   <= valid_d;
         ctrl_e    <= gate_ctrl(ctrl_d, valid_d);
         pc_e      <= pc_d;
         pcplus4_e <= pcplus4_d;
         rd1_e     <= opnd1;
         rd2_e     <= opnd2;
         immext_e  <= immext_d;
         rs1_e     <= rs1_d;
         rs2_e     <= rs2_d;
         rd_e      <= rd_d;
      end
   end

endmodule

// File: doc/idex_stage.md
# idex_stage

Decode-to-execute pipeline register for the RVX10 five-stage core. It sits directly downstream of the register file read ports and the decoder. Each cycle it captures the decoded instruction, its two source operands and its immediate, and presents them to the execute stage. It supports stall (hold), flush (bubble insertion) and an optional same-cycle writeback-to-decode operand bypass. The bypass is needed because the register file writes on the rising edge and reads combinationally.

## Interface
Parameters:
- XLEN, 32, datapath width
- REGA_W, 5, register address width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- stall_e  in  1  hold all E-stage registers
- flush_e  in  1  load a bubble into E
- valid_d  in  1  D-stage instruction valid
- ctrl_d  in  ctrl_t  decoded control bundle: regwrite, memwrite, jump, branch, alusrc, resultsrc[1:0], alucontrol[3:0]
- pc_d, pcplus4_d  in  XLEN  instruction PC and PC+4
- rs1_d, rs2_d, rd_d  in  REGA_W  source and destination register indices
- rd1_d, rd2_d  in  XLEN  register file read data
- immext_d  in  XLEN  sign-extended immediate
- regwrite_w  in  1  writeback write enable (register file we3)
- rd_w  in  REGA_W  writeback destination (register file a3)
- result_w  in  XLEN  writeback data (register file wd3)
- valid_e  out  1  E-stage instruction valid
- ctrl_e  out  ctrl_t  registered control bundle
- pc_e, pcplus4_e, rd1_e, rd2_e, immext_e  out  XLEN  registered data
- rs1_e, rs2_e, rd_e  out  REGA_W  registered indices, consumed by the hazard/forwarding unit

## Operation
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Per-edge priority: reset > flush_e > stall_e > load.
- Reset (asynchronous, taken immediately): every output is 0, so valid_e=0 and ctrl_e=0 (no regwrite, memwrite, jump or branch).
- flush_e=1: valid_e←0, ctrl_e←0, and all data and index outputs ←0. flush_e overrides stall_e when both are asserted.
- stall_e=1 with flush_e=0: every output keeps its value. WB activity during the stall does not modify the held rd1_e/rd2_e.
- Load: every output ← its _d counterpart.
  - ctrl_e is loaded as ctrl_d & {valid_d}: an invalid D instruction enters E as a bubble.
- Writeback bypass on load, per operand:
  - If regwrite_w && rd_w≠0 && rd_w==rs1_d, then rd1_e←result_w; otherwise rd1_e←rd1_d.
  - rd2_e follows the same rule using rs2_d.
  - When rs1_d==rs2_d==rd_w, both operands bypass.
  - rd_w==0 never bypasses, so x0 always reads 0.
- Bypass is evaluated only on load cycles. It has no effect during stall, flush or reset.

## Timing
- Latency: 1 cycle from D inputs to E outputs.
- Throughput: one instruction per cycle when stall_e=0.
- The bypass compare and mux lie on the D→E path: a 5-bit compare plus a 2:1 XLEN mux before the register.
- Reset deasserted mid-operation: the first rising edge after deassertion performs a normal load. There is no warm-up cycle.
- stall_e held for N cycles: outputs are frozen for N edges, and the first edge after release loads the current D values.
- A flush and a WB write in the same cycle produce a bubble; the bypass result is discarded.

## Configuration
- RVX10_WB_BYPASS_EN
  - Defined: the writeback bypass operates as specified above.
  - Undefined: rd1_e/rd2_e always load rd1_d/rd2_d unmodified. The regwrite_w, rd_w and result_w ports remain present but are unused, and same-cycle WB→D hazards must be handled elsewhere.

## Structure
- rvx10_pkg holds:
  - ctrl_t, a packed struct.
  - alu_op_t, a 4-bit enum covering the base ops plus the RVX10 custom ops.
  - the resultsrc encodings.
  - XLEN_DEF and REGA_W_DEF constants.
- Sub-module wb_bypass is instantiated twice, once per operand. Its ports are regwrite_w, rd_w, result_w, rs, rdata → opnd. It is purely combinational and wrapped by the RVX10_WB_BYPASS_EN guard.
- Everything else is a single always_ff @(posedge clk or posedge reset) block.

## Test plan
- Reset: assert reset mid-cycle while valid_e=1 → all outputs 0 immediately, before the next edge. Deassert reset with valid_d=1, pc_d=0x100 → after 1 edge, valid_e=1 and pc_e=0x100.
- Bypass: rs1_d=5, rd1_d=0x11, regwrite_w=1, rd_w=5, result_w=0xAB → rd1_e=0xAB, and rd2_e equals rd2_d. Repeat with rd_w=0 and rs1_d=0 → rd1_e=rd1_d. With the macro undefined → rd1_e=0x11.
- Stall: load pc_d=0x200, then hold stall_e=1 for 3 cycles while changing all D inputs and pulsing a matching WB write → outputs remain those of 0x200. Release stall_e → the new D values appear after 1 edge.
- Flush priority: stall_e=1, flush_e=1, ctrl_d.regwrite=1 → valid_e=0, ctrl_e=0, and all data outputs 0.
- Invalid D: valid_d=0, ctrl_d.memwrite=1 → valid_e=0 and ctrl_e.memwrite=0.
- Back-to-back: 8 consecutive instructions with pc 0x0, 0x4 … 0x1C and no stall → pc_e tracks the input with exactly 1 cycle of delay and no drops.
